// File: rtl/link_fault_pkg.sv
// link_fault_pkg: shared status encodings, FSM state type and default thresholds
// for the RX link-fault sequencer.
package link_fault_pkg;

    localparam logic [1:0] LF_OK     = 2'b00;
    localparam logic [1:0] LF_LOCAL  = 2'b01;
    localparam logic [1:0] LF_REMOTE = 2'b10;

    localparam int DEF_SEQ_THRESH = 4;
    localparam int DEF_COL_THRESH = 128;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_COUNT,
        ST_FAULT
    } lf_state_e;

endpackage

// File: rtl/link_fault_event_reg.sv
// link_fault_event_reg: single-entry Avalon-ST holding register; a new load
// overwrites any pending payload so only the latest status is delivered.
module link_fault_event_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [1:0] load_data,
    input  logic       out_ready,
    output logic [1:0] out_data,
    output logic       out_valid
);

    logic [1:0] r_data;
    logic       r_valid;

    // A load on the accepting edge wins, so the new value stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= 2'b00;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule

// File: rtl/link_fault_status_ctrl_rx.sv
// link_fault_status_ctrl_rx: RX RS link_fault state machine deciding the 2-bit
// fault status. Optional fault statistics under LINK_FAULT_STATUS_STATS_EN.
module link_fault_status_ctrl_rx
    import link_fault_pkg::*;
#(
    parameter int SEQ_THRESH = DEF_SEQ_THRESH,
    parameter int COL_THRESH = DEF_COL_THRESH,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       col_valid,
    input  logic       col_is_seq,
    input  logic [1:0] col_seq_type,
    output logic [1:0] link_fault_status,
    output logic [1:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       fault_active
`ifdef LINK_FAULT_STATUS_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] local_fault_cnt,
    output logic [15:0] remote_fault_cnt
`endif
);

    localparam logic [3:0]       SEQ_MAX = 4'(SEQ_THRESH);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COL_THRESH);

    lf_state_e        r_state, w_state_nxt;
    logic [1:0]       r_status, w_status_nxt;
    logic [1:0]       r_last_type, w_last_nxt;
    logic [3:0]       r_seq_cnt, w_seq_nxt;
    logic [CNT_W-1:0] r_col_cnt, w_col_nxt;
    logic             w_seq, w_ord, w_change;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_status    <= LF_OK;
            r_last_type <= LF_OK;
            r_seq_cnt   <= '0;
            r_col_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_status    <= w_status_nxt;
            r_last_type <= w_last_nxt;
            r_seq_cnt   <= w_seq_nxt;
            r_col_cnt   <= w_col_nxt;
        end
    end

    // Threshold tests use the already-updated counters so status moves on the
    // same edge that consumes the qualifying column.
    always_comb begin
        w_seq        = col_valid && col_is_seq && (col_seq_type == LF_LOCAL || col_seq_type == LF_REMOTE);
        w_ord        = col_valid && !w_seq;
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_last_nxt   = r_last_type;
        w_seq_nxt    = r_seq_cnt;
        w_col_nxt    = r_col_cnt;
        if (w_seq) begin
            w_col_nxt  = '0;
            w_last_nxt = col_seq_type;
            w_seq_nxt  = (col_seq_type != r_last_type) ? 4'd1 :
                         (r_seq_cnt == SEQ_MAX) ? SEQ_MAX : r_seq_cnt + 4'd1;
        end else if (w_ord) begin
            w_col_nxt = (r_col_cnt == COL_MAX) ? COL_MAX : r_col_cnt + CNT_W'(1);
        end
        case (r_state)
            ST_INIT: begin
                if (w_seq) w_state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_seq && w_seq_nxt == SEQ_MAX) begin
                    w_state_nxt  = ST_FAULT;
                    w_status_nxt = w_last_nxt;
                end else if (w_ord && w_col_nxt == COL_MAX) begin
                    w_state_nxt = ST_INIT;
                    w_seq_nxt   = '0;
                end
            end
            ST_FAULT: begin
                if (w_seq && w_seq_nxt == SEQ_MAX) begin
                    w_status_nxt = w_last_nxt;
                end else if (w_ord && w_col_nxt == COL_MAX) begin
                    w_state_nxt  = ST_INIT;
                    w_status_nxt = LF_OK;
                    w_seq_nxt    = '0;
                    w_last_nxt   = LF_OK;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        w_change = w_status_nxt != r_status;
    end

    link_fault_event_reg u_event (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_change),
        .load_data (w_status_nxt),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    assign link_fault_status = r_status;
    assign fault_active      = r_status != LF_OK;

`ifdef LINK_FAULT_STATUS_STATS_EN
    logic [15:0] r_local_cnt, r_remote_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_local_cnt  <= '0;
            r_remote_cnt <= '0;
        end else if (stats_clr) begin
            r_local_cnt  <= '0;
            r_remote_cnt <= '0;
        end else if (w_change) begin
            if (w_status_nxt == LF_LOCAL && r_local_cnt != 16'hFFFF)
                r_local_cnt <= r_local_cnt + 16'd1;
            if (w_status_nxt == LF_REMOTE && r_remote_cnt != 16'hFFFF)
                r_remote_cnt <= r_remote_cnt + 16'd1;
        end
    end

    assign local_fault_cnt  = r_local_cnt;
    assign remote_fault_cnt = r_remote_cnt;
`endif

endmodule

// File: tb/tb_link_fault_status_ctrl_rx.sv
// tb_link_fault_status_ctrl_rx: directed vectors for the RX link-fault
// sequencer with hand-computed expected status and event outputs.
module tb_link_fault_status_ctrl_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       col_valid, col_is_seq, out_ready;
    logic [1:0] col_seq_type;
    logic [1:0] link_fault_status, out_data;
    logic       out_valid, fault_active;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    link_fault_status_ctrl_rx dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .col_valid         (col_valid),
        .col_is_seq        (col_is_seq),
        .col_seq_type      (col_seq_type),
        .link_fault_status (link_fault_status),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .fault_active      (fault_active)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int n, input logic v, input logic s, input logic [1:0] t);
        for (int i = 0; i < n; i++) begin
            col_valid    = v;
            col_is_seq   = s;
            col_seq_type = t;
            @(posedge clk);
            #1;
        end
        col_valid = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic v, input logic [1:0] d);
        chk({tag, "_status"}, 16'(link_fault_status), 16'(st));
        chk({tag, "_fault"}, 16'(fault_active), 16'(st != 2'b00));
        chk({tag, "_valid"}, 16'(out_valid), 16'(v));
        if (v) chk({tag, "_data"}, 16'(out_data), 16'(d));
    endtask

    initial begin
        reset_n      = 1'b0;
        col_valid    = 1'b0;
        col_is_seq   = 1'b0;
        col_seq_type = 2'b00;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 2'b00, 1'b0, 2'b00);
        chk("reset_data", 16'(out_data), 16'h0);
        reset_n = 1'b1;

        // back-to-back local sequences
        send(3, 1, 1, 2'b01);
        chk_all("a_3loc", 2'b00, 1'b0, 2'b00);
        send(1, 1, 1, 2'b01);
        chk_all("a_4loc", 2'b01, 1'b1, 2'b01);
        send(1, 0, 0, 2'b00);
        chk_all("a_accept", 2'b01, 1'b0, 2'b00);

        // clear after exactly COL_THRESH ordinary columns
        send(127, 1, 0, 2'b00);
        chk_all("b_127ord", 2'b01, 1'b0, 2'b00);
        send(1, 1, 0, 2'b00);
        chk_all("b_128ord", 2'b00, 1'b1, 2'b00);

        // ordinary column does not reset seq_cnt
        send(3, 1, 1, 2'b01);
        send(1, 1, 0, 2'b00);
        chk_all("b_3l1o", 2'b00, 1'b0, 2'b00);
        send(1, 1, 1, 2'b01);
        chk_all("b_5th", 2'b01, 1'b1, 2'b01);

        // a sequence column restarts the clearing count
        send(127, 1, 0, 2'b00);
        send(1, 1, 1, 2'b01);
        chk_all("c_seqmid", 2'b01, 1'b0, 2'b00);
        send(127, 1, 0, 2'b00);
        chk_all("c_127again", 2'b01, 1'b0, 2'b00);
        send(1, 1, 0, 2'b00);
        chk_all("c_clear", 2'b00, 1'b1, 2'b00);

        // local -> remote with downstream stalled: single overwritten event
        out_ready = 1'b0;
        send(4, 1, 1, 2'b01);
        chk_all("d_loc", 2'b01, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) begin
            send(1, 1, 1, 2'b10);
            chk_all("d_rem_hold", 2'b01, 1'b1, 2'b01);
        end
        send(1, 1, 1, 2'b10);
        chk_all("d_rem4", 2'b10, 1'b1, 2'b10);
        out_ready = 1'b1;
        send(1, 0, 0, 2'b00);
        chk_all("d_accept", 2'b10, 1'b0, 2'b00);
        send(1, 0, 0, 2'b00);
        chk_all("d_single", 2'b10, 1'b0, 2'b00);

        // asynchronous reset between edges while remote fault
        #3 reset_n = 1'b0;
        #1;
        chk_all("e_async", 2'b00, 1'b0, 2'b00);
        #2 reset_n = 1'b1;
        send(3, 1, 1, 2'b10);
        chk_all("e_3rem", 2'b00, 1'b0, 2'b00);
        send(1, 1, 1, 2'b10);
        chk_all("e_4rem", 2'b10, 1'b1, 2'b10);

        // interleaved idle cycles and a type-11 column treated as ordinary
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        send(1, 1, 1, 2'b01);
        send(1, 0, 1, 2'b01);
        send(1, 1, 1, 2'b01);
        send(1, 0, 1, 2'b10);
        send(1, 1, 1, 2'b01);
        send(1, 0, 1, 2'b01);
        chk_all("f_3loc", 2'b00, 1'b0, 2'b00);
        send(1, 1, 1, 2'b11);
        chk_all("f_type11", 2'b00, 1'b0, 2'b00);
        send(1, 1, 1, 2'b01);
        chk_all("f_4loc", 2'b01, 1'b1, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/link_fault_status_ctrl_rx.md
Name: link_fault_status_ctrl_rx

Overview:
- RX Reconciliation Sublayer link-fault sequencer for the 10G MAC; implements the IEEE 802.3 Clause 46 link_fault state machine.
- Consumes per-column sequence ordered-set indications from the RX decoder and decides the 2-bit link fault status.
- Publishes that status as a level and as an Avalon-ST source (data/valid/ready). The source drives the link_fault_status RX timing adapter and, through it, MAC TX fault handling.
- Encoding: 00 = no fault, 01 = local fault, 10 = remote fault.

Parameters:
- SEQ_THRESH, 4: consecutive same-type sequence columns needed to declare a fault (2..15).
- COL_THRESH, 128: sequence-free columns needed to clear fault or counting state (2..255).
- CNT_W, 8: column counter width; must satisfy 2^CNT_W > COL_THRESH.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- col_valid  in  1  one received column qualified this cycle
- col_is_seq  in  1  qualified column is a sequence ordered set
- col_seq_type  in  2  01 local, 10 remote; meaningful only when col_is_seq
- link_fault_status  out  2  current decided status (registered level)
- out_data  out  2  status-change event payload
- out_valid  out  1  event pending
- out_ready  in  1  downstream accept
- fault_active  out  1  high when link_fault_status != 00

Behaviour:
- Reset, asynchronous, reset_n low: all outputs 0; state INIT; seq_cnt=0; col_cnt=0; last_type=00; no event pending.
- Column classes (evaluated only when col_valid=1):
  - Valid sequence column: col_is_seq=1 and col_seq_type is 01 or 10.
  - col_is_seq=1 with type 00 or 11: treated as an ordinary column.
  - col_valid=0: no state change.
- Every valid sequence column:
  - Clears col_cnt.
  - Same type as last_type: seq_cnt increments, saturating at SEQ_THRESH.
  - Different type: last_type takes the new type; seq_cnt=1.
- Every ordinary column increments col_cnt, saturating at COL_THRESH.
- States:
  - INIT: status 00. Valid sequence column -> COUNT.
  - COUNT: status unchanged from entry.
    - seq_cnt reaches SEQ_THRESH -> FAULT with status=last_type.
    - col_cnt reaches COL_THRESH -> INIT, seq_cnt=0.
  - FAULT: status holds.
    - A different-type sequence restarts seq_cnt with no status change. Reaching SEQ_THRESH on the new type updates status to that type; state stays FAULT.
    - col_cnt reaches COL_THRESH -> INIT, status 00, seq_cnt=0, last_type=00.
- Threshold comparisons use the post-update counter value. Status is registered: it changes on the clock edge that consumes the qualifying column, i.e. visible the next cycle. There are no extra cycles of latency.
- Event source:
  - Every change of link_fault_status loads out_data with the new value and sets out_valid in the same cycle as the change.
  - out_valid stays high until out_valid and out_ready are both high.
  - A further change while an event is pending overwrites out_data: latest wins, one event only.
  - A change coinciding with acceptance: out_valid stays 1 with the new value.
  - out_data is stable whenever out_valid=1 and no overwrite occurs.
- Downstream never backpressures in normal use. out_ready low is legal and only delays the event. The status level is never blocked.
- Reset mid-fault: immediate return to INIT/00. No event is generated for the reset itself.

Optional Feature:
- Macro: LINK_FAULT_STATUS_STATS_EN.
- Defined:
  - Adds outputs local_fault_cnt[15:0] and remote_fault_cnt[15:0], each incrementing on every entry into (or type switch to) the matching fault status, saturating at 0xFFFF.
  - Adds input stats_clr (1 bit, synchronous, active-high), which zeroes both counters.
  - Reset value 0.
- Undefined: these ports and the logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package link_fault_pkg:
  - Status encoding constants LF_OK=2'b00, LF_LOCAL=2'b01, LF_REMOTE=2'b10.
  - State enum INIT/COUNT/FAULT.
  - Default SEQ_THRESH and COL_THRESH constants.
- One natural sub-module, link_fault_event_reg: the single-entry overwrite-on-change Avalon-ST holding register.

Test Plan:
- 4 local sequence columns back-to-back -> status 01 one cycle after the 4th; out_valid=1, out_data=01; fault_active=1.
- 3 local, 1 ordinary, 1 local -> state COUNT, seq_cnt=4, status 01 after the 5th column, because ordinary columns do not reset seq_cnt.
- Status 01, then 128 ordinary columns -> status 00 exactly after the 128th. 127 ordinary columns followed by a sequence -> status stays 01 and col_cnt=0.
- Status 01, then 4 remote columns -> status 10 with no intermediate 00. With out_ready=0 throughout, out_data=10 and a single pending event.
- col_valid=0 cycles interleaved with 4 local columns -> same result as the back-to-back case. A column with col_is_seq=1, type 11 counts as ordinary.
- reset_n pulsed low while status=10, asynchronously between edges -> outputs 0 immediately. After release, 4 remote columns are required to re-fault.
